// File: rtl/lcd_frame_refresher_if.sv
// Handshake between the frame refresher and the LCD instruction transmitter.
//   next_instruction : 1-cycle pulse, db valid from this cycle (refresher -> transmitter)
//   db               : {RS, RW, D7..D0} instruction word   (refresher -> transmitter)
//   done             : 1-cycle pulse, instruction finished  (transmitter -> refresher)
interface lcd_frame_refresher_if;
  logic       next_instruction;
  logic [9:0] db;
  logic       done;

  modport master (output next_instruction, output db, input done);
  modport slave  (input next_instruction, input db, output done);
endinterface

// File: rtl/lcd_frame_refresher.sv
// HD44780-class LCD sequencer: power-up wait, init instructions, clear wait,
// then repeated repaint of a LINES x COLS character frame buffer.
// Ports:
//   clk, reset (async, active-low)
//   enable               : start / keep running (sampled in IDLE and WAIT_REFRESH)
//   cfg_cursor/cfg_blink : C/B bits used when the display-control word is issued
//   wr_en/wr_addr/wr_data: host write into the frame buffer (addr = line*COLS+col)
//   refresh_req          : request an early repaint
//   lcd                  : transmitter handshake (next_instruction, db, done)
//   busy                 : high in every state except IDLE
//   frame_done           : 1-cycle pulse after the last character of a frame is acknowledged
module lcd_frame_refresher #(
  parameter int LINES       = 2,
  parameter int COLS        = 16,
  parameter int PWR_CYC     = 750000,
  parameter int CLR_CYC     = 82000,
  parameter int REFRESH_CYC = 50000000,
  parameter int AW          = (LINES * COLS > 1) ? $clog2(LINES * COLS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_cursor,
  input  logic                  cfg_blink,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  refresh_req,
  lcd_frame_refresher_if.master lcd,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int          DEPTH     = LINES * COLS;
  localparam logic [31:0] PWR_LAST  = 32'(PWR_CYC - 1);
  localparam logic [31:0] CLR_LAST  = 32'(CLR_CYC - 1);
  localparam logic [31:0] REF_LAST  = 32'(REFRESH_CYC - 1);
  localparam logic [1:0]  LAST_LINE = 2'(LINES - 1);
  localparam logic [4:0]  LAST_COL  = 5'(COLS - 1);
  localparam logic [9:0]  FUNC_WORD = (LINES == 1) ? 10'h030 : 10'h038;

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, FUNC_SET, ENTRY_MODE, DISP_CTRL,
    CLEAR, CLR_WAIT, SET_ADDR, WRITE_CHAR, WAIT_REFRESH
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  line_q, line_d;
  logic [4:0]  col_q, col_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [9:0]  db_q, db_d;
  logic        ni_q, ni_d;
  logic        fd_q, fd_d;
  logic        issue;
  logic        in_wait;
  int          rd_idx;
  logic [7:0]  rd_char;
  logic [6:0]  base;
  logic [7:0]  buf_q [DEPTH];

  // Frame buffer. Out-of-range addresses match no entry and are dropped.
  // The character issued on a write edge is read from the pre-write contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h20;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == AW'(i)) buf_q[i] <= wr_data;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      db_q    <= '0;
      ni_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      db_q    <= db_d;
      ni_q    <= ni_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q;
    pend_d  = pend_q;
    if (refresh_req && state_q != IDLE && state_q != WAIT_REFRESH) pend_d = 1'b1;
    case (state_q)
      IDLE:       if (enable) state_d = PWR_WAIT;
      PWR_WAIT:   if (cnt_q == PWR_LAST) state_d = FUNC_SET;
      FUNC_SET:   if (lcd.done) state_d = ENTRY_MODE;
      ENTRY_MODE: if (lcd.done) state_d = DISP_CTRL;
      DISP_CTRL:  if (lcd.done) state_d = CLEAR;
      CLEAR:      if (lcd.done) state_d = CLR_WAIT;
      CLR_WAIT: begin
        if (cnt_q == CLR_LAST) begin
          state_d = SET_ADDR;
          line_d  = '0;
        end
      end
      SET_ADDR: begin
        if (lcd.done) begin
          state_d = WRITE_CHAR;
          col_d   = '0;
        end
      end
      WRITE_CHAR: begin
        if (lcd.done) begin
          if (col_q != LAST_COL) begin
            col_d = col_q + 5'd1;
          end else begin
            col_d = '0;
            if (line_q != LAST_LINE) begin
              line_d  = line_q + 2'd1;
              state_d = SET_ADDR;
            end else begin
              line_d  = '0;
              state_d = WAIT_REFRESH;
            end
          end
        end
      end
      WAIT_REFRESH: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pend_q || refresh_req) begin
          state_d = SET_ADDR;
          line_d  = '0;
          pend_d  = 1'b0;
        end else if (cnt_q == REF_LAST) begin
          state_d = SET_ADDR;
          line_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Wait counter restarts at zero whenever a wait state is entered.
    in_wait = (state_q == PWR_WAIT) || (state_q == CLR_WAIT) || (state_q == WAIT_REFRESH);
    cnt_d   = (in_wait && state_d == state_q) ? cnt_q + 32'd1 : 32'd0;
  end

  // Character for the position being entered (lookahead on line_d/col_d so
  // db is ready on the same edge as the state change).
  always_comb begin
    rd_idx  = int'(line_d) * COLS + int'(col_d);
    rd_char = 8'h20;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == i) rd_char = buf_q[i];
    end
    case (line_d)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'h14;
      default: base = 7'h54;
    endcase
  end

  // Output logic: a new word is launched on every state change and on each
  // in-place character advance; entering IDLE or a wait state clears db.
  always_comb begin
    db_d  = db_q;
    ni_d  = 1'b0;
    fd_d  = (state_q == WRITE_CHAR) && (state_d == WAIT_REFRESH);
    issue = (state_d != state_q) || (state_q == WRITE_CHAR && lcd.done);
    if (issue) begin
      ni_d = 1'b1;
      case (state_d)
        FUNC_SET:   db_d = FUNC_WORD;
        ENTRY_MODE: db_d = 10'h006;
        DISP_CTRL:  db_d = {8'h03, cfg_cursor, cfg_blink};
        CLEAR:      db_d = 10'h001;
        SET_ADDR:   db_d = {3'b001, base};
        WRITE_CHAR: db_d = {2'b10, rd_char};
        default: begin
          db_d = '0;
          ni_d = 1'b0;
        end
      endcase
    end
  end

  assign lcd.db               = db_q;
  assign lcd.next_instruction = ni_q;
  assign busy                 = (state_q != IDLE);
  assign frame_done           = fd_q;
endmodule

// File: tb/tb_lcd_frame_refresher.sv
// Scoreboard bench for lcd_frame_refresher: stimulus pushes expected
// instruction words (with expected spacing from the previous instruction)
// computed from the display rules; a monitor pops and compares on every
// next_instruction pulse. A responder answers every pulse with done 2 cycles later.
module tb_lcd_frame_refresher;
  localparam int LINES = 2;
  localparam int COLS  = 4;
  localparam int PWR   = 4;
  localparam int CLR   = 3;
  localparam int REFR  = 10;
  localparam int AW    = 4;
  localparam int RESP  = 2;
  localparam int DEPTH = LINES * COLS;

  typedef struct {
    logic [9:0] word;
    int         gap;
    bit         last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_cursor = 1'b0;
  logic          cfg_blink = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          refresh_req = 1'b0;
  logic          busy;
  logic          frame_done;

  lcd_frame_refresher_if lcd_if ();

  lcd_frame_refresher #(
    .LINES(LINES), .COLS(COLS), .PWR_CYC(PWR), .CLR_CYC(CLR),
    .REFRESH_CYC(REFR), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_cursor(cfg_cursor), .cfg_blink(cfg_blink),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh_req(refresh_req), .lcd(lcd_if),
    .busy(busy), .frame_done(frame_done)
  );

  exp_t       sb[$];
  logic [7:0] model_buf [DEPTH];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         fd_expect = -100;
  int         resp_cd = 0;
  bit         resp_en = 1'b1;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish by 200000 ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] line_base(input int l);
    case (l)
      0:       return 7'h00;
      1:       return 7'h40;
      2:       return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  task automatic push(input logic [9:0] w, input int gap, input bit last);
    exp_t e;
    e.word = w;
    e.gap  = gap;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic push_init(input int cur, input int blk);
    push((LINES == 1) ? 10'h030 : 10'h038, 1 + PWR, 1'b0);
    push(10'h006, RESP, 1'b0);
    push(10'(12 + 2 * cur + blk), RESP, 1'b0);
    push(10'h001, RESP, 1'b0);
  endtask

  task automatic push_frame(input int first_gap);
    for (int l = 0; l < LINES; l++) begin
      push({3'b001, line_base(l)}, (l == 0) ? first_gap : RESP, 1'b0);
      for (int c = 0; c < COLS; c++)
        push({2'b10, model_buf[l * COLS + c]}, RESP, (l == LINES - 1) && (c == COLS - 1));
    end
  endtask

  // ---------------- environment ----------------
  initial begin
    lcd_if.done = 1'b0;
    forever begin
      @(negedge clk);
      lcd_if.done = 1'b0;
      if (resp_cd != 0) begin
        lcd_if.done = 1'b1;
        resp_cd = 0;
      end
      if (resp_en && lcd_if.next_instruction) resp_cd = 1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (lcd_if.next_instruction) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: got db=0x%03h, expected no instruction (cycle %0d)",
                   lcd_if.db, cyc);
        end else begin
          e = sb.pop_front();
          $display("instr cycle %0d db=0x%03h expected 0x%03h gap %0d/%0d",
                   cyc, lcd_if.db, e.word, cyc - last_cyc, e.gap);
          check("db_word", int'(lcd_if.db), int'(e.word));
          check("issue_gap", cyc - last_cyc, e.gap);
          if (e.last) fd_expect = cyc + RESP;
        end
        last_cyc = cyc;
      end
      if (frame_done || cyc == fd_expect)
        check("frame_done", int'(frame_done), int'(cyc == fd_expect));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < DEPTH) model_buf[addr] = data;
  endtask

  task automatic wait_fd(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL wait_frame_done: got timeout after %0d cycles, expected a pulse", maxc);
    end
  endtask

  task automatic wait_pulses(input int n, input int maxc);
    int got = 0;
    for (int i = 0; i < maxc && got < n; i++) begin
      @(negedge clk);
      if (lcd_if.next_instruction) got++;
    end
    if (got < n) begin
      checks++;
      $display("FAIL wait_pulses: got %0d pulses, expected %0d", got, n);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    int a;
    for (int i = 0; i < DEPTH; i++) model_buf[i] = 8'h20;

    repeat (3) @(negedge clk);
    check("rst_db", int'(lcd_if.db), 0);
    check("rst_next_instruction", int'(lcd_if.next_instruction), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    reset = 1'b1;
    @(negedge clk);

    // "ABCD" / "WXYZ", then an out-of-range write that must not alias addr 0
    for (int i = 0; i < COLS; i++) wr(i, 8'(8'h41 + i));
    for (int i = 0; i < COLS; i++) wr(COLS + i, 8'(8'h57 + i));
    wr(8, 8'h21);

    last_cyc = cyc;
    push_init(0, 0);
    push_frame(RESP + CLR);
    push_frame(RESP + REFR);
    enable = 1'b1;
    @(negedge clk);
    check("busy_after_enable", int'(busy), 1);

    // frame 1 done; in frame 2 write addr 2 on the edge that issues it
    wait_fd(300);
    wait_pulses(3, 100);
    @(negedge clk);
    d = 8'($urandom_range(0, 255));
    if (d == 8'h43) d = 8'h63;
    wr(2, d);

    // frame 2 done; random writes (some out of range) during the idle gap
    wait_fd(300);
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, 15);
      if (a == 2) a = 3;
      wr(a, 8'($urandom_range(0, 255)));
    end
    push_frame(RESP + REFR);

    // early refresh requested mid frame 3 -> frame 4 after a 1-cycle wait
    wait_pulses(4, 100);
    @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    push_frame(RESP + 1);
    wait_fd(300);
    wait_fd(300);

    // stop while waiting for refresh
    enable = 1'b0;
    @(negedge clk);
    check("busy_after_stop", int'(busy), 0);
    check("db_after_stop", int'(lcd_if.db), 0);
    repeat (30) @(negedge clk);
    check("sb_empty_after_stop", sb.size(), 0);

    // restart with cursor+blink, then reset in the middle of character writes
    cfg_cursor = 1'b1;
    cfg_blink  = 1'b1;
    last_cyc = cyc;
    push_init(1, 1);
    push_frame(RESP + CLR);
    enable = 1'b1;
    wait_pulses(7, 200);
    #3;
    reset   = 1'b0;
    resp_en = 1'b0;
    #1;
    check("async_rst_db", int'(lcd_if.db), 0);
    check("async_rst_next_instruction", int'(lcd_if.next_instruction), 0);
    check("async_rst_busy", int'(busy), 0);
    sb.delete();
    for (int i = 0; i < DEPTH; i++) model_buf[i] = 8'h20;
    fd_expect = -100;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    resp_cd = 0;
    reset   = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    check("busy_after_reset", int'(busy), 0);

    last_cyc = cyc;
    push_init(1, 1);
    push_frame(RESP + CLR);
    enable = 1'b1;
    wait_fd(300);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("sb_empty_at_end", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
